superreg_sequencer: RTL



---
 rtl/superreg_pkg.sv | 39 +++
 rtl/superreg_sequencer_if.sv | 26 ++
 rtl/superreg_cmd_fifo.sv | 49 ++++
 rtl/superreg_sequencer.sv | 109 ++++++++++
 4 files changed

// File: rtl/superreg_pkg.sv
// Shared types for the super-register command sequencer: op encodings, FSM states and the
// queued command record.
package superreg_pkg;

    // Widest repeat count a queued command can carry; CNT_W on the sequencer must not exceed it.
    localparam int unsigned CMD_CNT_W = 16;

    typedef enum logic [2:0] {
        OP_LOAD = 3'd0,
        OP_DEC  = 3'd1,
        OP_INC  = 3'd2,
        OP_SET  = 3'd3,
        OP_CLR  = 3'd4,
        OP_SHR  = 3'd5,
        OP_SHL  = 3'd6,
        OP_HOLD = 3'd7
    } op_e;

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    typedef struct packed {
        op_e                  op;
        logic [3:0]           data;
        logic [CMD_CNT_W-1:0] count;
    } cmd_t;

    // Returns {rsi, lsi} for step k of a command.
    function automatic logic [1:0] serial_bits(op_e op, logic [3:0] data, logic [1:0] k);
        logic [1:0] bits;
        bits = 2'b00;
        if (op == OP_SHR) bits[1] = data[k];
        if (op == OP_SHL) bits[0] = data[k];
        return bits;
    endfunction

endpackage

// File: rtl/superreg_sequencer_if.sv
// Command handshake and register-drive bundle between a host and superreg_sequencer.
interface superreg_sequencer_if #(
    parameter int unsigned CNT_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [3:0]       cmd_data;
    logic [CNT_W-1:0] cmd_count;
    logic [2:0]       s;
    logic [3:0]       load;
    logic             rsi;
    logic             lsi;
    logic             busy;
    logic             last;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_count,
        input  cmd_ready, s, load, rsi, lsi, busy, last
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_count,
        output cmd_ready, s, load, rsi, lsi, busy, last
    );
endinterface

// File: rtl/superreg_cmd_fifo.sv
// Command queue of depth 1 or 2 with a registered head entry.
module superreg_cmd_fifo
    import superreg_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  cmd_t       i_data,
    input  logic       i_pop,
    output cmd_t       o_head,
    output logic       o_full,
    output logic       o_empty,
    output logic [1:0] o_count
);

    cmd_t       r_head;
    cmd_t       r_tail;
    logic [1:0] r_count;
    logic [1:0] w_after_pop;

    assign w_after_pop = r_count - {1'b0, i_pop};

    // A push lands in the first slot left free after this cycle's pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            r_count <= w_after_pop + {1'b0, i_push};
            if (i_push && (w_after_pop == 2'd0)) begin
                r_head <= i_data;
            end else if (i_pop) begin
                r_head <= r_tail;
            end
            if (i_push && (w_after_pop == 2'd1)) begin
                r_tail <= i_data;
            end
        end
    end

    assign o_head  = r_head;
    assign o_full  = (r_count == 2'(DEPTH));
    assign o_empty = (r_count == 2'd0);
    assign o_count = r_count;

endmodule

// File: rtl/superreg_sequencer.sv
// Expands queued register commands into per-cycle mode selects for the 4-bit super register.
// Define SUPERREG_SEQ_FIFO_EN for a 2-deep queue (one command per cycle); default depth is 1.
module superreg_sequencer
    import superreg_pkg::*;
#(
    parameter int unsigned CNT_W = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    superreg_sequencer_if.slave sq_if
);

`ifdef SUPERREG_SEQ_FIFO_EN
    localparam int unsigned QDepth = 2;
`else
    localparam int unsigned QDepth = 1;
`endif

    cmd_t             w_push_cmd;
    cmd_t             w_head;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [1:0]       w_count;
    logic [1:0]       w_cnt_next;
    logic             w_run_next;
    logic             w_busy_next;
    logic [CNT_W-1:0] w_rep_inc;

    state_e           r_state;
    logic [CNT_W-1:0] r_rep;
    logic [CNT_W-1:0] r_lim;
    logic [2:0]       r_s;
    logic [3:0]       r_load;
    logic             r_rsi;
    logic             r_lsi;
    logic             r_last;
    logic             r_busy;

    assign w_push     = sq_if.cmd_valid & ~w_full;
    assign w_push_cmd = '{op: op_e'(sq_if.cmd_op), data: sq_if.cmd_data,
                          count: CMD_CNT_W'(sq_if.cmd_count)};

    superreg_cmd_fifo #(
        .DEPTH (QDepth)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_push_cmd),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // r_last is only ever set in RUN, so it marks the final cycle of the current command.
    assign w_pop       = ~w_empty & ((r_state == StIdle) | r_last);
    assign w_rep_inc   = r_rep + 1'b1;
    assign w_cnt_next  = w_count - {1'b0, w_pop} + {1'b0, w_push};
    assign w_run_next  = w_pop | ((r_state == StRun) & ~r_last);
    assign w_busy_next = w_run_next | (w_cnt_next != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_rep   <= '0;
            r_lim   <= '0;
            r_s     <= OP_HOLD;
            r_load  <= 4'h0;
            r_rsi   <= 1'b0;
            r_lsi   <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_busy <= w_busy_next;
            if (w_pop) begin
                r_state        <= StRun;
                r_rep          <= '0;
                r_lim          <= w_head.count[CNT_W-1:0];
                r_s            <= w_head.op;
                r_load         <= w_head.data;
                {r_rsi, r_lsi} <= serial_bits(w_head.op, w_head.data, 2'd0);
                r_last         <= (w_head.count == '0);
            end else if ((r_state == StRun) && r_last) begin
                r_state <= StIdle;
                r_s     <= OP_HOLD;
                r_rsi   <= 1'b0;
                r_lsi   <= 1'b0;
                r_last  <= 1'b0;
            end else if (r_state == StRun) begin
                r_rep          <= w_rep_inc;
                {r_rsi, r_lsi} <= serial_bits(op_e'(r_s), r_load, 2'(w_rep_inc));
                r_last         <= (w_rep_inc == r_lim);
            end
        end
    end

    assign sq_if.cmd_ready = ~w_full;
    assign sq_if.s         = r_s;
    assign sq_if.load      = r_load;
    assign sq_if.rsi       = r_rsi;
    assign sq_if.lsi       = r_lsi;
    assign sq_if.busy      = r_busy;
    assign sq_if.last      = r_last;

endmodule
